// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the pipelined bitwise logic unit.
// Holds the 3-bit operation encodings used by the datapath and by anything
// that drives it (including the bench).
package logic_unit_pipe_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NOT  = 3'd0;  // ~a
  localparam op_t OP_AND  = 3'd1;  // a & b
  localparam op_t OP_OR   = 3'd2;  // a | b
  localparam op_t OP_XOR  = 3'd3;  // a ^ b
  localparam op_t OP_NAND = 3'd4;  // ~(a & b)
  localparam op_t OP_NOR  = 3'd5;  // ~(a | b)
  localparam op_t OP_XNOR = 3'd6;  // ~(a ^ b)
  localparam op_t OP_PASS = 3'd7;  // a

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise operation core.
// Ports:
//   op     in  OP_W   operation select (logic_unit_pipe_pkg encodings)
//   a      in  WIDTH  operand A
//   b      in  WIDTH  operand B (unused by NOT/PASS)
//   result out WIDTH  bitwise result, no carry or sign semantics
module logic_op_core
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    result = '0;
    case (op)
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_PASS: result = a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes.
// Stage 1 registers {op, a, b}; stage 2 registers the result plus zero and
// parity flags. Full throughput, two-cycle latency, stalls propagate backwards.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      a/b/op carry a transaction
//   in_ready   out  1      unit accepts a transaction this cycle
//   op         in   OP_W   operation select
//   a, b       in   WIDTH  operands
//   out_valid  out  1      out/zero/parity carry a result
//   out_ready  in   1      consumer accepts the result this cycle
//   out        out  WIDTH  result
//   zero       out  1      out == 0
//   parity     out  1      XOR-reduction of out
module logic_unit_pipe
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             parity
);

  logic             s1_valid;
  op_t              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_result;
  logic             s1_ready;
  logic             s2_ready;

  // A stage can take a new beat when it is empty or its contents leave this
  // cycle. This is the only combinational path (out_ready -> in_ready).
  assign s2_ready = !out_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;

  logic_op_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (s1_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      s1_valid  <= 1'b0;
      s1_op     <= OP_NOT;
      s1_a      <= '0;
      s1_b      <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      zero      <= 1'b1;
      parity    <= 1'b0;
    end else begin
      // Stage 1: refill when it drains; operands only move on a real transfer.
      if (s1_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op <= op;
          s1_a  <= a;
          s1_b  <= b;
        end
      end
      // Stage 2: result and flags stay frozen while the consumer stalls.
      if (s2_ready) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out    <= s1_result;
          zero   <= ~|s1_result;
          parity <= ^s1_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe at WIDTH = 8, 32 and 1.
// All three instances share clock, reset, in_valid, op and out_ready.
module tb_logic_unit_pipe;
  import logic_unit_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  op_t         op = OP_NOT;
  logic [7:0]  a8 = '0, b8 = '0, out8;
  logic [31:0] a32 = '0, b32 = '0, out32;
  logic        a1 = 1'b0, b1 = 1'b0, out1;
  logic        ir8, ov8, z8, p8;
  logic        ir32, ov32, z32, p32;
  logic        ir1, ov1, z1, p1;

  int checks = 0;
  int errors = 0;

  logic [31:0] q [3][$];

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .op(op),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(out_ready), .out(out8),
    .zero(z8), .parity(p8));

  logic_unit_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32), .op(op),
    .a(a32), .b(b32), .out_valid(ov32), .out_ready(out_ready), .out(out32),
    .zero(z32), .parity(p32));

  logic_unit_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .op(op),
    .a(a1), .b(b1), .out_valid(ov1), .out_ready(out_ready), .out(out1),
    .zero(z1), .parity(p1));

  typedef struct {
    op_t        op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vt [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: each op is a 2-input truth table applied independently per bit,
  // table index = {a_bit, b_bit}.
  function automatic logic [31:0] model(input op_t o, input logic [31:0] x,
                                        input logic [31:0] y, input int w);
    logic [3:0]  tt;
    logic [31:0] r;
    tt = 4'b0000;
    r  = '0;
    case (o)
      OP_NOT:  tt = 4'b0011;
      OP_AND:  tt = 4'b1000;
      OP_OR:   tt = 4'b1110;
      OP_XOR:  tt = 4'b0110;
      OP_NAND: tt = 4'b0111;
      OP_NOR:  tt = 4'b0001;
      OP_XNOR: tt = 4'b1001;
      OP_PASS: tt = 4'b1100;
      default: tt = 4'b0000;
    endcase
    for (int i = 0; i < w; i++) r[i] = tt[{x[i], y[i]}];
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard step for instance k, called at the negedge of a cycle.
  task automatic sb_step(input int k, input int w, input logic ir, input logic ov,
                         input logic [31:0] ain, input logic [31:0] bin,
                         input logic [31:0] o, input logic z, input logic p);
    logic [31:0] e;
    if (ov && out_ready) begin
      if (q[k].size() == 0) begin
        check($sformatf("sb_spurious_w%0d", w), 32'd1, 32'd0);
      end else begin
        e = q[k].pop_front();
        check($sformatf("sb_out_w%0d", w), o, e);
        check($sformatf("sb_zero_w%0d", w), {31'd0, z}, {31'd0, e == 0});
        check($sformatf("sb_parity_w%0d", w), {31'd0, p}, {31'd0, ^e});
      end
    end
    if (in_valid && ir) q[k].push_back(model(op, ain, bin, w));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] bp_exp [3];
    logic       prev_hold;
    logic [7:0] prev_out;

    vt[0]  = '{OP_NOT,  8'hF0, 8'h00, 8'h0F};
    vt[1]  = '{OP_NOT,  8'hAA, 8'h00, 8'h55};
    vt[2]  = '{OP_NOT,  8'h33, 8'h00, 8'hCC};
    vt[3]  = '{OP_NOT,  8'hE7, 8'h00, 8'h18};
    vt[4]  = '{OP_AND,  8'hAA, 8'h0F, 8'h0A};
    vt[5]  = '{OP_OR,   8'hAA, 8'h0F, 8'hAF};
    vt[6]  = '{OP_XOR,  8'hAA, 8'h0F, 8'hA5};
    vt[7]  = '{OP_NAND, 8'hAA, 8'h0F, 8'hF5};
    vt[8]  = '{OP_NOR,  8'hAA, 8'h0F, 8'h50};
    vt[9]  = '{OP_XNOR, 8'hAA, 8'h0F, 8'h5A};
    vt[10] = '{OP_XOR,  8'h3C, 8'h3C, 8'h00};

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, ov8}, 32'd0);
    check("rst_out", {24'd0, out8}, 32'd0);
    check("rst_zero", {31'd0, z8}, 32'd1);
    check("rst_parity", {31'd0, p8}, 32'd0);
    check("rst_in_ready", {31'd0, ir8}, 32'd1);
    next_cycle();

    // Table vectors streamed back to back with out_ready=1
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i < 11) begin
        in_valid = 1'b1; op = vt[i].op; a8 = vt[i].a; b8 = vt[i].b;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("tbl_in_ready", {31'd0, ir8}, 32'd1);
      if (i >= 2) begin
        check($sformatf("tbl_valid_%0d", i - 2), {31'd0, ov8}, 32'd1);
        check($sformatf("tbl_out_%0d", i - 2), {24'd0, out8}, {24'd0, vt[i-2].exp});
        check($sformatf("tbl_zero_%0d", i - 2), {31'd0, z8}, {31'd0, vt[i-2].exp == 8'h00});
        check($sformatf("tbl_parity_%0d", i - 2), {31'd0, p8}, {31'd0, ^vt[i-2].exp});
      end
      next_cycle();
    end
    @(negedge clk);
    check("tbl_drained", {31'd0, ov8}, 32'd0);
    next_cycle();

    // Backpressure: out_ready low, three beats offered, only two accepted
    out_ready = 1'b0;
    bp_exp[0] = 8'hFE; bp_exp[1] = 8'hFD; bp_exp[2] = 8'hFC;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; op = OP_NOT; a8 = 8'(i + 1);
      @(negedge clk);
      check($sformatf("bp_accept_%0d", i), {31'd0, ir8}, 32'd1);
      next_cycle();
    end
    a8 = 8'h03;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", {31'd0, ir8}, 32'd0);
      check("bp_hold_valid", {31'd0, ov8}, 32'd1);
      check("bp_hold_out", {24'd0, out8}, {24'd0, bp_exp[0]});
      next_cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) check("bp_release_ready", {31'd0, ir8}, 32'd1);
      if (i < 3) begin
        check($sformatf("bp_drain_valid_%0d", i), {31'd0, ov8}, 32'd1);
        check($sformatf("bp_drain_out_%0d", i), {24'd0, out8}, {24'd0, bp_exp[i]});
      end else begin
        check("bp_no_dup", {31'd0, ov8}, 32'd0);
      end
      next_cycle();
      in_valid = 1'b0;
    end

    // Ten beats back to back: no bubbles
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        in_valid = 1'b1; op = op_t'(i % 8); a8 = 8'(i * 37 + 5); b8 = 8'(i * 91 + 3);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i >= 2) begin
        check($sformatf("thr_valid_%0d", i - 2), {31'd0, ov8}, 32'd1);
        check($sformatf("thr_out_%0d", i - 2), {24'd0, out8},
              model(op_t'((i - 2) % 8), 32'((i - 2) * 37 + 5) & 32'hFF,
                    32'((i - 2) * 91 + 3) & 32'hFF, 8));
      end
      next_cycle();
    end

    // Reset with two beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; op = OP_PASS; a8 = 8'h5A + 8'(i);
      next_cycle();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {31'd0, ov8}, 32'd0);
    check("mid_rst_out", {24'd0, out8}, 32'd0);
    check("mid_rst_zero", {31'd0, z8}, 32'd1);
    check("mid_rst_in_ready", {31'd0, ir8}, 32'd1);
    next_cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_discard", {31'd0, ov8}, 32'd0);
      next_cycle();
    end

    // Wide and narrow instances
    in_valid = 1'b1; op = OP_NOT; a32 = 32'hFFFF0000; a1 = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    check("w32_valid", {31'd0, ov32}, 32'd1);
    check("w32_out", out32, 32'h0000FFFF);
    check("w32_parity", {31'd0, p32}, 32'd0);
    check("w32_zero", {31'd0, z32}, 32'd0);
    check("w1_out", {31'd0, out1}, 32'd0);
    check("w1_zero", {31'd0, z1}, 32'd1);
    next_cycle();
    next_cycle();

    // Random ops, operands and stalls against the per-bit model
    prev_hold = 1'b0;
    prev_out  = '0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = op_t'($urandom_range(0, 7));
      a8 = 8'($urandom); b8 = 8'($urandom);
      a32 = $urandom; b32 = $urandom;
      a1 = 1'($urandom); b1 = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (prev_hold) begin
        check("rnd_hold_valid", {31'd0, ov8}, 32'd1);
        check("rnd_hold_out", {24'd0, out8}, {24'd0, prev_out});
      end
      sb_step(0, 8, ir8, ov8, {24'd0, a8}, {24'd0, b8}, {24'd0, out8}, z8, p8);
      sb_step(1, 32, ir32, ov32, a32, b32, out32, z32, p32);
      sb_step(2, 1, ir1, ov1, {31'd0, a1}, {31'd0, b1}, {31'd0, out1}, z1, p1);
      prev_hold = ov8 && !out_ready;
      prev_out  = out8;
      next_cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      sb_step(0, 8, ir8, ov8, {24'd0, a8}, {24'd0, b8}, {24'd0, out8}, z8, p8);
      sb_step(1, 32, ir32, ov32, a32, b32, out32, z32, p32);
      sb_step(2, 1, ir1, ov1, {31'd0, a1}, {31'd0, b1}, {31'd0, out1}, z1, p1);
      next_cycle();
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sb_empty_%0d", k), 32'(q[k].size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
